// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the default datapath width.
package muldiv_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNT_W = 5;

    // op[1] selects divide, op[0] selects unsigned
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage : muldiv_pkg

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
//   is_div    : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_in    : {upper, lower} accumulator
//               multiply: {partial product, remaining multiplier bits}
//               divide  : {partial remainder, dividend/quotient bits}
//   opnd      : multiplicand (multiply) or divisor (divide), magnitude form
//   acc_out_c : accumulator after this iteration
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_out_c
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Multiply: add multiplicand into the upper half when the current multiplier bit is set
    assign add_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : '0);

    // Divide: bring the next dividend bit into the remainder and try the subtract
    assign rem_sh  = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, opnd};

    // Select: a borrow (diff MSB) means the trial subtract failed, keep the shifted remainder
    always_comb begin
        acc_out_c = acc_in;
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_out_c = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out_c = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_out_c = {add_sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule : muldiv_step

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
//   clk, rst     : clock, asynchronous active-low reset
//   start        : request, accepted only while idle (including the done cycle)
//   op           : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         : rs / rt operands
//   busy         : operation in progress
//   done         : one-cycle completion pulse
//   div_by_zero  : set when the last operation was a divide by zero
//   hi, lo       : HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 is_div;
    logic                 is_signed;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 res_neg;
    logic                 rem_neg;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [2*WIDTH-1:0]   step_acc_c;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];

    // Operand magnitudes; a_q/b_q stay raw so signs and the div-by-zero HI value survive
    assign a_mag = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign b_mag = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    // Sign correction applied at FIX; most-negative values wrap naturally
    assign res_neg  = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    assign rem_neg  = is_signed & a_q[WIDTH-1];
    assign prod_fix = res_neg ? -acc_q : acc_q;
    assign quot_fix = res_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = rem_neg ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div    (is_div),
        .acc_in    (acc_q),
        .opnd      (opnd_q),
        .acc_out_c (step_acc_c)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op_e'(op);
                    a_d     = a;
                    b_d     = b;
                    dbz_d   = 1'b0;
                    state_d = PREP;
                end
            end
            PREP: begin
                if (is_div && (b_q == '0)) begin
                    state_d = DONE;
                end else begin
                    // Multiply keeps the multiplier in the low half; divide keeps the dividend there
                    opnd_d  = is_div ? b_mag : a_mag;
                    acc_d   = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = step_acc_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            DONE: begin
                hi_d    = a_q;
                lo_d    = '1;
                dbz_d   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule : muldiv_unit

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations compared against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_unit #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, MIPS semantics
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el,
                         output logic ed, output int elat);
        longint          sx, sy, sq, sr;
        longint unsigned up;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        ed   = 1'b0;
        elat = 34;
        eh   = '0;
        el   = '0;
        if (o[1] && (y == 32'd0)) begin
            eh   = x;
            el   = 32'hFFFF_FFFF;
            ed   = 1'b1;
            elat = 2;
        end else begin
            case (o)
                2'b00: begin
                    sq = sx * sy;
                    eh = sq[63:32];
                    el = sq[31:0];
                end
                2'b01: begin
                    up = {32'd0, x} * {32'd0, y};
                    eh = up[63:32];
                    el = up[31:0];
                end
                2'b10: begin
                    sq = sx / sy;
                    sr = sx % sy;
                    el = sq[31:0];
                    eh = sr[31:0];
                end
                default: begin
                    el = x / y;
                    eh = x % y;
                end
            endcase
        end
    endtask

    // Issue one op from a negedge where the unit is idle (or in its done cycle).
    // poke_at >= 0 drives a stray start with junk operands at that cycle.
    // Returns at the negedge of the done cycle.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int poke_at);
        logic [31:0] eh, el;
        logic        ed;
        int          elat, lat, busy_cnt;
        model(o, x, y, eh, el, ed, elat);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        @(negedge clk);
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            start = (lat == poke_at);
            op    = 2'($urandom);
            a     = $urandom;
            b     = $urandom;
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, 64'(lat), 64'(elat));
        chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(elat));
        chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, ".hi"}, 64'(hi), 64'(eh));
        chk({tag, ".lo"}, 64'(lo), 64'(el));
        chk({tag, ".dbz"}, 64'(div_by_zero), 64'(ed));
    endtask

    // One idle cycle: done must drop and HI/LO must hold
    task automatic idle_check(input string tag);
        logic [31:0] h0, l0;
        h0 = hi;
        l0 = lo;
        @(negedge clk);
        chk({tag, ".done_pulse"}, 64'(done), 64'd0);
        chk({tag, ".hold"}, {hi, lo}, {h0, l0});
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        rst   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.dbz", 64'(div_by_zero), 64'd0);
        chk("reset.hilo", {hi, lo}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        idle_check("multu_max");
        do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, -1);
        do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, -1);          // back-to-back start
        do_op("divu", 2'b11, 32'd100, 32'd7, -1);
        do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        idle_check("div_ovf");
        do_op("divu_zero", 2'b11, 32'h1234_5678, 32'd0, -1);
        idle_check("divu_zero");
        do_op("clear_dbz", 2'b01, 32'd3, 32'd4, -1);
        do_op("div_zero_s", 2'b10, 32'h8765_4321, 32'd0, -1);
        do_op("ignored_start", 2'b01, 32'd5, 32'd6, 4);
        idle_check("ignored_start");

        // Asynchronous reset in the middle of a running multiply
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd5;
        b     = 32'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst.busy", 64'(busy), 64'd0);
        chk("async_rst.done", 64'(done), 64'd0);
        chk("async_rst.hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_op("after_rst", 2'b01, 32'd5, 32'd6, -1);
        idle_check("after_rst");

        // Randomized operations, some with zero or extreme divisors
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: ry = 32'($urandom_range(1, 9));
                2: rx = 32'h8000_0000;
                3: ry = 32'hFFFF_FFFF;
                default: ;
            endcase
            do_op($sformatf("rand%0d", i), ro, rx, ry, ($urandom_range(0, 3) == 0) ? 7 : -1);
            if (i % 3 == 0) idle_check($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_muldiv_unit
